// File: rtl/dl_common_pkg.sv
// Shared types and constants for the lab's input-conditioning blocks.
package dl_common_pkg;

  // Debouncer FSM states. The encoding makes bit 1 the debounced level and
  // bit 0 the "candidate change pending" flag.
  typedef enum logic [1:0] {
    LOW       = 2'd0,
    HIGH_PEND = 2'd1,
    HIGH      = 2'd2,
    LOW_PEND  = 2'd3
  } deb_state_t;

  localparam int DEB_STABLE_DEFAULT = 4;

  // Width of a counter that has to hold 0..stable_cycles.
  function automatic int deb_cnt_w(input int stable_cycles);
    return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchronizer for one asynchronous input bit.
// No logic between stages; s is the last stage. SYNC_STAGES must be >= 2.
module sync_chain #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
)(
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic s
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the raw input through the chain; reset loads the idle level.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) chain <= {SYNC_STAGES{RESET_LEVEL}};
    else      chain <= {chain[SYNC_STAGES-2:0], din};
  end

  assign s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Debouncer + synchronizer feeding the lab's preset/clear DFF d input.
// A change of the synchronized input must persist STABLE_CYCLES cycles
// before d_out follows; rise/fall are one-cycle registered edge pulses.
// Optional feature: define DEBOUNCE_BYPASS_EN to add the bypass input,
// which makes d_out track the synchronized input with one cycle delay.
module debounce_sync
  import dl_common_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = DEB_STABLE_DEFAULT,
  parameter logic RESET_LEVEL   = 1'b0,
  parameter int   CNT_W         = deb_cnt_w(STABLE_CYCLES)
)(
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic d_out,
  output logic rise,
  output logic fall,
  output logic busy
`ifdef DEBOUNCE_BYPASS_EN
  ,
  input  logic bypass
`endif
);

  localparam deb_state_t       RST_STATE = RESET_LEVEL ? HIGH : LOW;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  // With a one-cycle qualification window the pending states are skipped.
  localparam bit               ONE_SHOT  = (STABLE_CYCLES == 1);

  logic             s;
  logic             byp;
  deb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             d_out_nxt, rise_nxt, fall_nxt, busy_nxt;

  sync_chain #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk (clk),
    .clr (clr),
    .din (din),
    .s   (s)
  );

`ifdef DEBOUNCE_BYPASS_EN
  assign byp = bypass;
`else
  assign byp = 1'b0;
`endif

  // State and stability counter registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: qualify a change of s against the current debounced level.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (byp) begin
      // Bypass parks the FSM in the stable state matching s; any pending
      // change is dropped.
      state_nxt = s ? HIGH : LOW;
      cnt_nxt   = '0;
    end else begin
      case (state)
        LOW: begin
          if (s) begin
            if (ONE_SHOT) state_nxt = HIGH;
            else begin
              state_nxt = HIGH_PEND;
              cnt_nxt   = CNT_ONE;
            end
          end
        end
        HIGH_PEND: begin
          if (!s) begin
            state_nxt = LOW;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = HIGH;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        HIGH: begin
          if (!s) begin
            if (ONE_SHOT) state_nxt = LOW;
            else begin
              state_nxt = LOW_PEND;
              cnt_nxt   = CNT_ONE;
            end
          end
        end
        LOW_PEND: begin
          if (s) begin
            state_nxt = HIGH;
            cnt_nxt   = '0;
          end else if (cnt == CNT_LAST) begin
            state_nxt = LOW;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = RST_STATE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output decode of the next state; edges compare against the current level.
  always_comb begin
    d_out_nxt = (state_nxt == HIGH) || (state_nxt == LOW_PEND);
    busy_nxt  = (state_nxt == HIGH_PEND) || (state_nxt == LOW_PEND);
    rise_nxt  = d_out_nxt & ~d_out;
    fall_nxt  = ~d_out_nxt & d_out;
  end

  // Output flops so every port is driven straight from a register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      d_out <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      d_out <= d_out_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
      busy  <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync: default instance (a) and a
// SYNC_STAGES=3 / STABLE_CYCLES=1 instance (b). Expected output vectors
// {d_out,rise,fall,busy} are queued per cycle and checked at negedge.
module tb_debounce_sync;

  logic clk = 1'b0;
  logic clr, din_a, din_b;
  logic d_out_a, rise_a, fall_a, busy_a;
  logic d_out_b, rise_b, fall_b, busy_b;
  logic [3:0] obs_a, obs_b;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    bit         inst;
    logic [3:0] exp;
    string      tag;
  } sb_t;
  sb_t sbq[$];

  debounce_sync dut_a (
    .clk   (clk),
    .clr   (clr),
    .din   (din_a),
    .d_out (d_out_a),
    .rise  (rise_a),
    .fall  (fall_a),
    .busy  (busy_a)
`ifdef DEBOUNCE_BYPASS_EN
    ,
    .bypass(1'b0)
`endif
  );

  debounce_sync #(.SYNC_STAGES(3), .STABLE_CYCLES(1)) dut_b (
    .clk   (clk),
    .clr   (clr),
    .din   (din_b),
    .d_out (d_out_b),
    .rise  (rise_b),
    .fall  (fall_b),
    .busy  (busy_b)
`ifdef DEBOUNCE_BYPASS_EN
    ,
    .bypass(1'b0)
`endif
  );

  assign obs_a = {d_out_a, rise_a, fall_a, busy_a};
  assign obs_b = {d_out_b, rise_b, fall_b, busy_b};

  always #37 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push(input bit inst, input int c, input logic [3:0] e, input string tag);
    sb_t x;
    x.cyc = c; x.inst = inst; x.exp = e; x.tag = tag;
    sbq.push_back(x);
  endtask

  // Wait until the monitor has checked cycle k, then step past the negedge.
  task automatic to_cyc(input int k);
    while (cyc < k) @(negedge clk);
    #1;
  endtask

  // din_a driven 0->1 at cycle c while stable LOW: rise at c+6.
  task automatic exp_rise(input int c, input string tag);
    push(0, c+1, 4'b0000, tag); push(0, c+2, 4'b0000, tag);
    for (int i = 3; i <= 5; i++) push(0, c+i, 4'b0001, tag);
    push(0, c+6, 4'b1100, tag); push(0, c+7, 4'b1000, tag);
  endtask

  // din_a driven 1->0 at cycle c while stable HIGH: fall at c+6.
  task automatic exp_fall(input int c, input string tag);
    push(0, c+1, 4'b1000, tag); push(0, c+2, 4'b1000, tag);
    for (int i = 3; i <= 5; i++) push(0, c+i, 4'b1001, tag);
    push(0, c+6, 4'b0010, tag); push(0, c+7, 4'b0000, tag);
  endtask

  // Compare queued expectations when the DUT reaches their cycle.
  always @(negedge clk) begin
    sb_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      chk($sformatf("%s@%0d", e.tag, e.cyc), e.inst ? obs_b : obs_a, e.exp);
    end
  end

  initial begin
    int c;
    logic lvl, prev;
    clr = 1'b1; din_a = 1'b0; din_b = 1'b0;
    #5 clr = 1'b0;
    #15;
    chk("rst_a", obs_a, 4'b0000);
    chk("rst_b", obs_b, 4'b0000);
    #30 clr = 1'b1;

    // Clean rise, din goes high at 80 ns.
    #30 din_a = 1'b1; c = cyc;
    exp_rise(c, "rise1");
    to_cyc(c + 8);

    // Clean fall.
    c = cyc; din_a = 1'b0;
    exp_fall(c, "fall1");
    to_cyc(c + 8);

    // Two-edge glitch is rejected.
    c = cyc; din_a = 1'b1;
    push(0, c+1, 4'b0000, "glitch"); push(0, c+2, 4'b0000, "glitch");
    push(0, c+3, 4'b0001, "glitch"); push(0, c+4, 4'b0001, "glitch");
    for (int i = 5; i <= 8; i++) push(0, c+i, 4'b0000, "glitch");
    to_cyc(c + 2); din_a = 1'b0;
    to_cyc(c + 5);
    chk("glitch_cnt", 4'(dut_a.cnt), 4'b0000);
    to_cyc(c + 9);

    // Bounce train 1,0,1,0 then stable 1.
    c = cyc; din_a = 1'b1;
    push(0, c+1, 4'b0000, "bounce"); push(0, c+2, 4'b0000, "bounce");
    push(0, c+3, 4'b0001, "bounce"); push(0, c+4, 4'b0000, "bounce");
    push(0, c+5, 4'b0001, "bounce"); push(0, c+6, 4'b0000, "bounce");
    for (int i = 7; i <= 9; i++) push(0, c+i, 4'b0001, "bounce");
    push(0, c+10, 4'b1100, "bounce"); push(0, c+11, 4'b1000, "bounce");
    to_cyc(c + 1); din_a = 1'b0;
    to_cyc(c + 2); din_a = 1'b1;
    to_cyc(c + 3); din_a = 1'b0;
    to_cyc(c + 4); din_a = 1'b1;
    to_cyc(c + 12);

    // Fall again, then abort a pending rise with clr.
    c = cyc; din_a = 1'b0;
    exp_fall(c, "fall2");
    to_cyc(c + 8);
    c = cyc; din_a = 1'b1;
    push(0, c+3, 4'b0001, "pend"); push(0, c+4, 4'b0001, "pend");
    to_cyc(c + 4);
    clr = 1'b0;
    #5 chk("clr_async", obs_a, 4'b0000);
    #15 clr = 1'b1;
    push(0, c+5, 4'b0000, "rerun"); push(0, c+6, 4'b0000, "rerun");
    for (int i = 7; i <= 9; i++) push(0, c+i, 4'b0001, "rerun");
    push(0, c+10, 4'b1100, "rerun"); push(0, c+11, 4'b1000, "rerun");
    to_cyc(c + 12);

    // Instance b: toggle every 4 cycles, output follows at c+4.
    c = cyc; prev = 1'b0; lvl = 1'b1;
    for (int k = 0; k < 4; k++) begin
      to_cyc(c + 4*k);
      din_b = lvl;
      for (int i = 1; i <= 3; i++) push(1, c + 4*k + i, {prev, 3'b000}, "tog");
      push(1, c + 4*k + 4, {lvl, lvl, ~lvl, 1'b0}, "tog");
      prev = lvl; lvl = ~lvl;
    end
    push(1, c + 17, {prev, 3'b000}, "tog");
    to_cyc(c + 19);

    total++;
    assert (sbq.size() == 0) else begin
      bad++;
      $error("FAIL sb_drain observed=%0d expected=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditions a raw, asynchronous, possibly bouncing input (switch or button) into a clean, clock-synchronous level for the D input of the lab's preset/clear D flip-flop stage.
- Adds one-cycle edge pulses for downstream counters and sequence detectors.
- Sits directly upstream of the DFF: its d_out drives that flip-flop's d.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops, minimum 2.
- STABLE_CYCLES, 4, consecutive cycles the synchronized input must differ from d_out before d_out flips, minimum 1.
- RESET_LEVEL, 1'b0, value loaded into the synchronizer chain and d_out by reset.
- CNT_W, $clog2(STABLE_CYCLES+1), stability counter width; derived, do not override.

Ports:
- clk  input  1  single clock, rising-edge active
- clr  input  1  asynchronous reset, active-low (0 = reset)
- din  input  1  raw asynchronous input
- d_out  output  1  debounced, synchronized level
- rise  output  1  one-cycle pulse, d_out went 0->1
- fall  output  1  one-cycle pulse, d_out went 1->0
- busy  output  1  high while a candidate change is being qualified (state *_PEND)

Behaviour:
- Reset (clr=0, asynchronous, takes effect immediately, no clock needed):
  - Every sync flop = RESET_LEVEL, d_out = RESET_LEVEL, cnt = 0, rise = fall = busy = 0.
  - State = HIGH if RESET_LEVEL else LOW.
- Release of clr: the first active edge processes normally. No extra settling cycle.
- Synchronizer: plain shift chain of SYNC_STAGES flops; s = last stage. No logic between stages.
- FSM states: LOW, HIGH_PEND, HIGH, LOW_PEND. d_out = 1 in HIGH and LOW_PEND, else 0.
- LOW:
  - s=1: cnt <= 1, go HIGH_PEND. If STABLE_CYCLES=1, go directly to HIGH instead.
  - s=0: stay.
- HIGH_PEND:
  - s=0: cnt <= 0, back to LOW. This is glitch rejection; no pulse.
  - s=1 and cnt == STABLE_CYCLES-1: go HIGH, cnt <= 0, rise <= 1.
  - else: cnt <= cnt+1.
- HIGH and LOW_PEND mirror LOW and HIGH_PEND with polarity swapped; the qualifying transition sets fall <= 1.
- busy = 1 exactly in HIGH_PEND and LOW_PEND.
- Latency: if din changes before edge N and is held, d_out, rise and fall change at edge N + SYNC_STAGES + STABLE_CYCLES - 1. Default is N+5.
- rise and fall:
  - Registered, high for exactly one cycle, never both high together.
  - Cleared on the following edge unless a new qualifying transition occurs. That cannot happen within STABLE_CYCLES, so back-to-back pulses are impossible for STABLE_CYCLES>1.
- A run of s differing from d_out for fewer than STABLE_CYCLES cycles never changes d_out.
- cnt never exceeds STABLE_CYCLES-1 and has no wrap path.
- clr asserted while in a *_PEND state abandons the pending change. Any pulse in flight is cleared immediately.
- Outputs are glitch-free: every output comes directly from a flop.

Optional Feature:
- Macro DEBOUNCE_BYPASS_EN.
- Defined:
  - Adds input port bypass (1 bit).
  - When bypass=1, the stability qualification is skipped: d_out follows s with one register of delay, and rise/fall are still generated on each change.
  - The FSM is held in the stable state matching d_out with cnt = 0; busy = 0.
  - Switching bypass mid-pending drops the pending change.
- Not defined: no bypass port; behaviour exactly as above.

Decomposition:
- Package dl_common_pkg:
  - typedef enum logic [1:0] deb_state_t {LOW, HIGH_PEND, HIGH, LOW_PEND}.
  - Function for CNT_W.
  - Constant DEB_STABLE_DEFAULT = 4.
- Sub-module sync_chain: parameterized SYNC_STAGES, RESET_LEVEL, same clk/clr. Reused for every asynchronous input in later labs.
- FSM, counter and pulse flops stay in debounce_sync.

Test Plan:
- Default params, clk period 74 ns, clr=0 for 50 ns then 1; din rises 1->held at t=80 ns → d_out=1 and one-cycle rise at the 5th clk edge after the first edge sampling din=1; fall never asserted.
- din high for 2 edges then low (bounce) → busy pulses high, d_out stays 0, rise and fall never assert, cnt back to 0.
- Bounce train 1,0,1,0 at edge rate, then stable 1 → d_out rises exactly STABLE_CYCLES edges after the first s=1 of the stable run; exactly one rise pulse.
- d_out=1, din falls and is held → d_out=0 and fall pulse at N+5; then clr pulsed low for 20 ns mid-HIGH_PEND of the next rise → d_out=0, busy=0 immediately, without waiting for an edge.
- STABLE_CYCLES=1, SYNC_STAGES=3: din toggles every 4 cycles → d_out follows with 3-edge latency; alternating rise/fall pulses, each 1 cycle.
- DEBOUNCE_BYPASS_EN defined, bypass=1: 1-cycle din glitch → d_out glitches 1 cycle after s; rise then fall on consecutive edges; busy stays 0.
